// File: rtl/ahb2fifo_resp.sv
// AHB-side response collector: tracks each data phase and packs the
// completed read beats / write bursts into the rdata, resp and id_resp FIFOs.
module ahb2fifo_resp #(
    parameter int          DW       = 64,
    parameter int          IDW      = 8,
    parameter logic [1:0]  ERR_RESP = 2'b10
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             addr_accept,
    input  logic [IDW-1:0]   addr_id,
    input  logic             addr_write,
    input  logic             addr_last,
    input  logic             hready,
    input  logic             hresp,
    input  logic [DW-1:0]    hrdata,
    input  logic             fifo_full,
    input  logic             fifo_afull,
    output logic             hold_issue,
    output logic             rdata_w_en,
    output logic [DW-1:0]    axi_rdata,
    output logic             resp_w_en,
    output logic [1:0]       axi_resp,
    output logic             id_resp_w_en,
    output logic [IDW+1:0]   axi_id_resp,
    output logic             ovf_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DPH  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_capture;
    logic             w_done;
    logic             w_push;
    logic             w_err_tot;

    logic [IDW-1:0]   r_id;
    logic             r_write;
    logic             r_last;
    logic             r_wr_err;

    logic             r_w_en;
    logic [DW-1:0]    r_rdata;
    logic [1:0]       r_resp;
    logic [IDW+1:0]   r_id_resp;
    logic             r_ovf;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Address accepted while a data phase is stalled is illegal and ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (addr_accept) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DPH;
                end
            end
            S_DPH: begin
                if (hready) begin
                    w_done      = 1'b1;
                    w_capture   = addr_accept;
                    w_state_nxt = addr_accept ? S_DPH : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_push    = w_done & (~r_write | r_last);
    assign w_err_tot = hresp | (r_write & r_wr_err);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_write <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_capture) begin
            r_id    <= addr_id;
            r_write <= addr_write;
            r_last  <= addr_last;
        end
    end

    // Error status merged across the beats of one write burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_err <= 1'b0;
        end else if (w_done && r_write) begin
            r_wr_err <= r_last ? 1'b0 : (r_wr_err | hresp);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_w_en    <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
            r_id_resp <= '0;
        end else begin
            r_w_en <= w_push;
            if (w_push) begin
                r_rdata   <= r_write ? '0 : hrdata;
                r_resp    <= w_err_tot ? ERR_RESP : 2'b00;
                r_id_resp <= {r_write, r_last, r_id};
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_ovf <= 1'b0;
        else          r_ovf <= r_ovf | (r_w_en & fifo_full);
    end

    assign hold_issue   = fifo_afull;
    assign rdata_w_en   = r_w_en;
    assign resp_w_en    = r_w_en;
    assign id_resp_w_en = r_w_en;
    assign axi_rdata    = r_rdata;
    assign axi_resp     = r_resp;
    assign axi_id_resp  = r_id_resp;
    assign ovf_err      = r_ovf;

endmodule

// File: tb/tb_ahb2fifo_resp.sv
// Directed + randomized bench for ahb2fifo_resp with a burst-level
// reference model of the expected FIFO pushes.
module tb_ahb2fifo_resp;

    localparam int DW  = 64;
    localparam int IDW = 8;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             addr_accept;
    logic [IDW-1:0]   addr_id;
    logic             addr_write;
    logic             addr_last;
    logic             hready;
    logic             hresp;
    logic [DW-1:0]    hrdata;
    logic             fifo_full;
    logic             fifo_afull;
    logic             hold_issue;
    logic             rdata_w_en;
    logic [DW-1:0]    axi_rdata;
    logic             resp_w_en;
    logic [1:0]       axi_resp;
    logic             id_resp_w_en;
    logic [IDW+1:0]   axi_id_resp;
    logic             ovf_err;

    ahb2fifo_resp #(.DW(DW), .IDW(IDW), .ERR_RESP(2'b10)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .addr_accept  (addr_accept),
        .addr_id      (addr_id),
        .addr_write   (addr_write),
        .addr_last    (addr_last),
        .hready       (hready),
        .hresp        (hresp),
        .hrdata       (hrdata),
        .fifo_full    (fifo_full),
        .fifo_afull   (fifo_afull),
        .hold_issue   (hold_issue),
        .rdata_w_en   (rdata_w_en),
        .axi_rdata    (axi_rdata),
        .resp_w_en    (resp_w_en),
        .axi_resp     (axi_resp),
        .id_resp_w_en (id_resp_w_en),
        .axi_id_resp  (axi_id_resp),
        .ovf_err      (ovf_err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Model state: what the next edge should push, and the sticky overflow.
    logic             e_push;
    logic [DW-1:0]    e_rdata;
    logic [1:0]       e_resp;
    logic [IDW+1:0]   e_id;
    logic             ovf_exp;
    logic             prev_push;
    logic             rnd_afull;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (prev_push && fifo_full) ovf_exp = 1'b1;
        @(posedge aclk);
        #1;
        chk("w_en", {rdata_w_en, resp_w_en, id_resp_w_en},
            e_push ? 128'd7 : 128'd0);
        if (e_push) begin
            chk("rdata", axi_rdata, e_rdata);
            chk("resp", axi_resp, e_resp);
            chk("id_resp", axi_id_resp, e_id);
        end
        chk("ovf_err", ovf_err, ovf_exp);
        chk("hold_issue", hold_issue, fifo_afull);
        prev_push   = e_push;
        e_push      = 1'b0;
        addr_accept = 1'b0;
        hready      = 1'b1;
        hresp       = 1'b0;
        hrdata      = {$urandom, $urandom};
        if (rnd_afull) fifo_afull = $urandom_range(1, 0) == 1;
    endtask

    // One AXI burst driven onto AHB; beat i errors when errm[i] is set.
    task automatic burst(input logic [IDW-1:0] id, input logic wr,
                         input int len, input logic [3:0] errm,
                         input int wmin, input int wmax, input bit fixed);
        logic          acc;
        int            w;
        logic [DW-1:0] d;
        acc         = 1'b0;
        addr_accept = 1'b1;
        addr_id     = id;
        addr_write  = wr;
        addr_last   = (len == 1);
        tick();
        for (int i = 0; i < len; i++) begin
            w = $urandom_range(wmax, wmin);
            if (errm[i] && w == 0) w = 1;
            for (int k = 0; k < w; k++) begin
                hready = 1'b0;
                hresp  = errm[i] && (k == w - 1);
                tick();
            end
            d      = fixed ? DW'((i + 1) * 'h11) : {$urandom, $urandom};
            hready = 1'b1;
            hresp  = errm[i];
            hrdata = d;
            acc    = acc | errm[i];
            if (i < len - 1) begin
                addr_accept = 1'b1;
                addr_id     = id;
                addr_write  = wr;
                addr_last   = (i + 1 == len - 1);
            end
            if (!wr) begin
                e_push  = 1'b1;
                e_rdata = d;
                e_resp  = errm[i] ? 2'b10 : 2'b00;
                e_id    = {1'b0, (i == len - 1), id};
            end else if (i == len - 1) begin
                e_push  = 1'b1;
                e_rdata = '0;
                e_resp  = acc ? 2'b10 : 2'b00;
                e_id    = {2'b11, id};
            end
            tick();
        end
    endtask

    initial begin
        aresetn     = 1'b0;
        addr_accept = 1'b0;
        addr_id     = '0;
        addr_write  = 1'b0;
        addr_last   = 1'b0;
        hready      = 1'b1;
        hresp       = 1'b0;
        hrdata      = '0;
        fifo_full   = 1'b0;
        fifo_afull  = 1'b1;
        e_push      = 1'b0;
        e_rdata     = '0;
        e_resp      = 2'b00;
        e_id        = '0;
        ovf_exp     = 1'b0;
        prev_push   = 1'b0;
        rnd_afull   = 1'b0;

        #1;
        chk("rst_w_en", {rdata_w_en, resp_w_en, id_resp_w_en}, 128'd0);
        chk("rst_rdata", axi_rdata, 128'd0);
        chk("rst_resp", axi_resp, 128'd0);
        chk("rst_id", axi_id_resp, 128'd0);
        chk("rst_ovf", ovf_err, 128'd0);
        chk("rst_hold", hold_issue, 128'd1);
        fifo_afull = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        // Read burst, zero wait states, data 0x11..0x44.
        burst(8'h3A, 1'b0, 4, 4'b0000, 0, 0, 1'b1);
        tick();
        // Write burst with a two-cycle ERROR on beat 2, then a clean one.
        burst(8'h05, 1'b1, 4, 4'b0010, 0, 0, 1'b0);
        burst(8'h06, 1'b1, 4, 4'b0000, 0, 0, 1'b0);
        // Read single with three wait states.
        burst(8'hFF, 1'b0, 1, 4'b0000, 3, 3, 1'b0);
        tick();

        rnd_afull = 1'b1;
        for (int n = 0; n < 40; n++) begin
            burst(IDW'($urandom), 1'($urandom), $urandom_range(4, 1),
                  4'($urandom & $urandom & $urandom), 0, 2, 1'b0);
            if ($urandom_range(2, 0) == 0) tick();
        end
        rnd_afull  = 1'b0;
        fifo_afull = 1'b0;
        tick();

        // Push while the FIFO is full: still pushed, overflow goes sticky.
        fifo_full  = 1'b1;
        fifo_afull = 1'b1;
        burst(8'h21, 1'b0, 1, 4'b0000, 0, 1, 1'b0);
        tick();
        fifo_full = 1'b0;
        tick();
        tick();
        fifo_afull = 1'b0;

        // Reset while the second beat of a read burst is in its data phase.
        addr_accept = 1'b1;
        addr_id     = 8'h42;
        addr_write  = 1'b0;
        addr_last   = 1'b0;
        tick();
        addr_accept = 1'b1;
        addr_id     = 8'h42;
        addr_last   = 1'b1;
        hrdata      = 64'hDEAD_BEEF_0000_0001;
        e_push      = 1'b1;
        e_rdata     = 64'hDEAD_BEEF_0000_0001;
        e_resp      = 2'b00;
        e_id        = {2'b00, 8'h42};
        tick();
        hready  = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("arst_w_en", {rdata_w_en, resp_w_en, id_resp_w_en}, 128'd0);
        chk("arst_rdata", axi_rdata, 128'd0);
        chk("arst_id", axi_id_resp, 128'd0);
        chk("arst_ovf", ovf_err, 128'd0);
        ovf_exp   = 1'b0;
        prev_push = 1'b0;
        hready    = 1'b1;
        tick();
        aresetn = 1'b1;
        tick();
        tick();
        tick();
        burst(8'h77, 1'b0, 2, 4'b0001, 0, 1, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb2fifo_resp.md
Name: ahb2fifo_resp

Overview:
- Response-collection stage on the AHB side of the AXI-to-AHB bridge.
- Tracks each AHB transfer from its accepted address phase to its completed data phase.
- Packs the result into the three response FIFOs (rdata, resp, id_resp); the downstream FIFO-to-AXI stage pops all three together.
- Read beats: one entry per beat. Write bursts: one entry per burst, on the last beat, with the burst's merged error status.

Parameters:
- DW, 64, AHB read-data width; equals the rdata FIFO width.
- IDW, 8, AXI ID width; the id_resp word is IDW+2 bits.
- ERR_RESP, 2'b10, AXI response code pushed for an AHB ERROR (SLVERR); OKAY is 2'b00.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- addr_accept  in  1  pulse: an AHB address phase (NONSEQ/SEQ) was accepted this cycle (htrans[1]&hready).
- addr_id  in  IDW  AXI ID of the accepted transfer.
- addr_write  in  1  1 = write transfer.
- addr_last  in  1  1 = last beat of its AXI burst.
- hready  in  1  AHB HREADY (bus).
- hresp  in  1  AHB HRESP (1 = ERROR).
- hrdata  in  DW  AHB HRDATA.
- fifo_full  in  1  OR of the three FIFO full flags.
- fifo_afull  in  1  OR of almost-full flags; asserted when at most 1 entry is free.
- hold_issue  out  1  combinational copy of fifo_afull; the address-side FSM must not accept new beats while high.
- rdata_w_en  out  1  rdata FIFO push.
- axi_rdata  out  DW  rdata FIFO write word.
- resp_w_en  out  1  resp FIFO push.
- axi_resp  out  2  resp FIFO write word.
- id_resp_w_en  out  1  id_resp FIFO push.
- axi_id_resp  out  IDW+2  id_resp FIFO write word: [IDW+1] = write, [IDW] = last/bvalid, [IDW-1:0] = id.
- ovf_err  out  1  sticky: a push was attempted while fifo_full.

Behaviour:
- Reset (async, aresetn=0):
  - All outputs 0 except hold_issue, which follows fifo_afull.
  - FSM goes to IDLE; data-phase registers and write-error accumulator are cleared.
  - A beat in flight when reset asserts is discarded; no push occurs after reset releases until a new beat completes.
- FSM states: IDLE (no data phase pending), DPH (data phase pending).
  - IDLE + addr_accept: capture id/write/last into data-phase registers -> DPH.
  - DPH + hready=0: hold (wait states, or first cycle of a two-cycle ERROR).
  - DPH + hready=1: beat completes. If addr_accept is also high (pipelined next beat), capture the new beat and stay in DPH; otherwise -> IDLE.
  - addr_accept while in DPH with hready=0 cannot legally occur; it is ignored.
- Beat completion (edge where DPH and hready=1):
  - Error sampled as hresp on that cycle.
  - Read beat: push axi_rdata=hrdata, axi_resp = error ? ERR_RESP : 2'b00, axi_id_resp = {0, last, id}.
  - Write beat, not last: push nothing; wr_err |= error.
  - Write beat, last: push axi_resp = (wr_err|error) ? ERR_RESP : 2'b00, axi_rdata=0, axi_id_resp = {1, 1, id}; clear wr_err.
- Push timing:
  - The three w_en outputs are registered, identical, and high for exactly one cycle, the cycle after the completing edge. Latency: 1 cycle from hready to push.
  - Data words are valid in the same cycle as w_en and are held otherwise.
- Overflow: if fifo_full is high in the push cycle, the w_en outputs are still driven (the FIFO ignores the push), and ovf_err is set and stays set until reset.
- Back-to-back completions (one per cycle) produce one push per cycle with no bubble.
- The write-error accumulator is a single register; the address side never interleaves write bursts.

Test Plan:
- Read burst, 4 beats, id 0x3A, zero wait states, data 0x11..0x44 -> 4 consecutive pushes, id_resp 0x03A,0x03A,0x03A,0x13A, resp 00, rdata in order, each one cycle after its hready.
- Write burst, 4 beats, id 0x05; beat 2 two-cycle ERROR -> exactly one push after beat 4: id_resp 0x305, resp 2'b10, rdata 0. A following clean write burst id 0x06 -> id_resp 0x306, resp 00.
- Read single, id 0xFF, 3 wait states (hready low 3 cycles) -> no push during waits; one push 0x1FF with hrdata sampled on the hready=1 cycle.
- Reset asserted during DPH of a read beat -> all outputs 0 immediately; after release, no push until a new addr_accept completes.
- fifo_full held high while a read beat completes -> w_en pulses and ovf_err rises and stays 1; fifo_afull=1 -> hold_issue=1 in the same cycle.
